alu_arbiter: RTL

//  Shares one alu instance between two requesters (req 0: execute stage, req 1: address/aux unit).

---
 rtl/alu_arb_pkg.sv | 41 ++++
 rtl/alu_arbiter_alu.sv | 50 +++++
 rtl/alu_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
//   Shared definitions for the alu_arbiter block:
//   - state_t     : arbiter FSM encoding (IDLE / EXEC / RESP)
//   - alu_op_t    : 4-bit alu control code
//   - ALU_*       : defined alu operation codes, ALU_OP_MAX is the last valid one
//   - is_shift_op : true for the ops whose B operand is a shift amount
//   - is_undef_op : true for op codes above ALU_OP_MAX
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_SLL  = 4'b0010;
  localparam alu_op_t ALU_SLT  = 4'b0011;
  localparam alu_op_t ALU_SLTU = 4'b0100;
  localparam alu_op_t ALU_XOR  = 4'b0101;
  localparam alu_op_t ALU_SRL  = 4'b0110;
  localparam alu_op_t ALU_SRA  = 4'b0111;
  localparam alu_op_t ALU_OR   = 4'b1000;
  localparam alu_op_t ALU_AND  = 4'b1001;

  localparam alu_op_t ALU_OP_MAX = ALU_AND;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_undef_op(input alu_op_t op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu
//   Purely combinational integer alu.
//   Ports:
//     a, b       in  WIDTH  operands
//     op         in  4      control code (see alu_arb_pkg)
//     alu_out    out WIDTH  result; zero for undefined codes
//     a_is_zero  out 1      operand A equals zero
//   Shifts use the whole B operand as the shift distance, so a distance of
//   WIDTH or more shifts everything out. Callers that want modulo-WIDTH
//   shifts mask B before it reaches this block.
// ---------------------------------------------------------------------------
module alu
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] alu_out,
  output logic             a_is_zero
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;
  assign a_is_zero   = (a == '0);

  always_comb begin
    // NOTE: default assignment first so every path drives alu_out (no latch).
    alu_out = '0;
    case (op)
      ALU_ADD:  alu_out = a + b;
      ALU_SUB:  alu_out = a - b;
      ALU_SLL:  alu_out = a << b;
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, lt_unsigned};
      ALU_XOR:  alu_out = a ^ b;
      ALU_SRL:  alu_out = a >> b;
      ALU_SRA:  alu_out = $unsigned($signed(a) >>> b);
      ALU_OR:   alu_out = a | b;
      ALU_AND:  alu_out = a & b;
      default:  alu_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one alu between two requesters (0: execute stage, 1: aux unit).
//   A three-state FSM (IDLE -> EXEC -> RESP) serialises operations; the
//   result and flags are returned only to the requester that was granted.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     req_valid[1:0]      request valid per requester
//     req_ready[1:0]      request accepted this cycle (IDLE only)
//     req_a0/1, req_b0/1  operands per requester
//     req_op0/1           alu control code per requester
//     rsp_valid[1:0]      response valid, one-hot to the granted requester
//     rsp_ready[1:0]      response accept; only the granted bit is used
//     rsp_data            result (zero when the op code is undefined)
//     rsp_a_zero          latched operand A was zero
//     rsp_err             op code was undefined (> ALU_OP_MAX)
//     busy                FSM not in IDLE
//
//   Configuration macro ALU_ARB_RR_EN:
//     defined   -> round-robin tie break (winner != last_grant)
//     undefined -> fixed priority, requester 0 wins ties
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_a_zero,
  output logic             rsp_err,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SHAMT_MASK = WIDTH'((64'd1 << SHW) - 64'd1);

  state_t state_q, state_d;

  logic             grant_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  alu_op_t          op_q;

  logic             winner;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  alu_op_t          sel_op;

  logic [WIDTH-1:0] alu_out;
  logic             alu_a_zero;
  logic             rsp_done;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    winner = 1'b0;
    if (&req_valid) begin
`ifdef ALU_ARB_RR_EN
      winner = ~last_grant_q;
`else
      winner = 1'b0;
`endif
    end else begin
      winner = req_valid[1];
    end
  end

`ifndef ALU_ARB_RR_EN
  // last_grant is kept up to date for both builds but only steers the
  // round-robin variant.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // Qualified with rst_n so req_ready stays low while reset is asserted.
  assign accept = rst_n && (state_q == ST_IDLE) && (|req_valid);

  // Shift distances are reduced modulo WIDTH before they are latched.
  always_comb begin
    sel_a  = winner ? req_a1  : req_a0;
    sel_b  = winner ? req_b1  : req_b0;
    sel_op = winner ? req_op1 : req_op0;
    if (is_shift_op(sel_op)) begin
      sel_b = sel_b & SHAMT_MASK;
    end
  end

  assign rsp_done = (state_q == ST_RESP) && rsp_ready[grant_q];

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_EXEC;
      ST_EXEC:               state_d = ST_RESP;
      ST_RESP: if (rsp_done) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (accept) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
    if (state_q == ST_RESP) begin
      rsp_valid = grant_q ? 2'b10 : 2'b01;
    end
    busy = (state_q != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  // NOTE: the operand registers carry no reset; they are only read in EXEC,
  // which is always preceded by a load, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= sel_a;
      b_q  <= sel_b;
      op_q <= sel_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_data     <= '0;
      rsp_a_zero   <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        grant_q <= winner;
      end
      if (state_q == ST_EXEC) begin
        rsp_err    <= is_undef_op(op_q);
        rsp_data   <= is_undef_op(op_q) ? '0 : alu_out;
        rsp_a_zero <= alu_a_zero;
      end
      if (rsp_done) begin
        last_grant_q <= grant_q;
      end
    end
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .alu_out  (alu_out),
    .a_is_zero(alu_a_zero)
  );

endmodule
